// File: rtl/clk_period_meter_if.sv
// Measurement bundle for clk_period_meter: the divided clock under test,
// edge pulses, the period/high-time result with its valid/ready handshake, and status flags.
interface clk_period_meter_if #(
  parameter int CNT_W = 16
);
  logic             sig_in;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             meas_ready;
  logic             meas_lost;
  logic             stall;

  modport master (
    input  sig_in,
    input  meas_ready,
    output rise_pulse,
    output fall_pulse,
    output period,
    output high_time,
    output meas_valid,
    output meas_lost,
    output stall
  );

  modport slave (
    output sig_in,
    output meas_ready,
    input  rise_pulse,
    input  fall_pulse,
    input  period,
    input  high_time,
    input  meas_valid,
    input  meas_lost,
    input  stall
  );
endinterface

// File: rtl/clk_period_meter.sv
// Monitors a divided clock in the source domain: flags its edges, measures period and
// high time in source cycles, hands results out over valid/ready and detects a stalled divider.
module clk_period_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 0,
  parameter int TIMEOUT     = 1000
) (
  input  logic                i_clk_in,
  input  logic                i_rst,
  clk_period_meter_if.master  io_bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  logic             w_s;
  logic             r_s_q;
  logic             r_rise;
  logic             r_fall;
  logic             w_rise;
  logic             w_fall;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] w_hcnt_nxt;
  logic             w_timeout;
  logic             w_new_meas;
  logic [CNT_W-1:0] w_meas_high;
  logic             w_stall_set;

  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high_time;
  logic             r_valid;
  logic             r_lost;
  logic             r_stall;
  logic             w_xfer;
  logic             w_drop;
  logic             w_load;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_s = io_bus.sig_in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync;
      always_ff @(posedge i_clk_in) begin
        if (i_rst) begin
          r_sync <= '0;
        end else begin
          r_sync[0] <= io_bus.sig_in;
          for (int k = 1; k < SYNC_STAGES; k++) begin
            r_sync[k] <= r_sync[k-1];
          end
        end
      end
      assign w_s = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  assign w_rise = w_s & ~r_s_q;
  assign w_fall = ~w_s & r_s_q;

  always_ff @(posedge i_clk_in) begin
    if (i_rst) begin
      r_s_q  <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_s_q  <= w_s;
      r_rise <= w_rise;
      r_fall <= w_fall;
    end
  end

  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT));

  always_ff @(posedge i_clk_in) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hcnt  <= w_hcnt_nxt;
    end
  end

  // A rise always wins: it closes the running period before any timeout is considered.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hcnt_nxt  = r_hcnt;
    w_new_meas  = 1'b0;
    w_meas_high = r_hcnt;
    w_stall_set = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_state_nxt = HIGH;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      HIGH: begin
        if (w_rise) begin
          w_new_meas  = 1'b1;
          w_meas_high = r_cnt;
          w_hcnt_nxt  = r_cnt;
          w_cnt_nxt   = CNT_W'(1);
        end else if (w_timeout) begin
          w_state_nxt = IDLE;
          w_stall_set = 1'b1;
        end else if (w_fall) begin
          w_hcnt_nxt  = r_cnt;
          w_state_nxt = LOW;
          w_cnt_nxt   = w_cnt_inc;
        end else begin
          w_cnt_nxt   = w_cnt_inc;
        end
      end
      LOW: begin
        if (w_rise) begin
          w_new_meas  = 1'b1;
          w_state_nxt = HIGH;
          w_cnt_nxt   = CNT_W'(1);
        end else if (w_timeout) begin
          w_state_nxt = IDLE;
          w_stall_set = 1'b1;
        end else begin
          w_cnt_nxt   = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_xfer = r_valid & io_bus.meas_ready;
  assign w_drop = w_new_meas & r_valid & ~w_xfer;
  assign w_load = w_new_meas & ~w_drop;

  // Result registers only change on a load, so they stay stable while valid is held.
  always_ff @(posedge i_clk_in) begin
    if (i_rst) begin
      r_period    <= '0;
      r_high_time <= '0;
      r_valid     <= 1'b0;
      r_lost      <= 1'b0;
      r_stall     <= 1'b0;
    end else begin
      if (w_load) begin
        r_period    <= r_cnt;
        r_high_time <= w_meas_high;
        r_valid     <= 1'b1;
      end else if (w_xfer) begin
        r_valid     <= 1'b0;
      end
      if (w_drop) begin
        r_lost <= 1'b1;
      end else if (w_xfer) begin
        r_lost <= 1'b0;
      end
      if (w_rise) begin
        r_stall <= 1'b0;
      end else if (w_stall_set) begin
        r_stall <= 1'b1;
      end
    end
  end

  assign io_bus.rise_pulse = r_rise;
  assign io_bus.fall_pulse = r_fall;
  assign io_bus.period     = r_period;
  assign io_bus.high_time  = r_high_time;
  assign io_bus.meas_valid = r_valid;
  assign io_bus.meas_lost  = r_lost;
  assign io_bus.stall      = r_stall;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: one unsynchronised meter (TIMEOUT=20) and one
// with a two-flop synchroniser share the same divided-clock stimulus.
module tb_clk_period_meter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nVectors = 0;
  int   nMiscompares = 0;
  int   nValid = 0;

  always #5 clk = ~clk;

  clk_period_meter_if #(.CNT_W(16)) bus0 ();
  clk_period_meter_if #(.CNT_W(16)) bus2 ();

  clk_period_meter #(.CNT_W(16), .SYNC_STAGES(0), .TIMEOUT(20)) dut0 (
    .i_clk_in (clk),
    .i_rst    (rst),
    .io_bus   (bus0)
  );

  clk_period_meter #(.CNT_W(16), .SYNC_STAGES(2), .TIMEOUT(20)) dut2 (
    .i_clk_in (clk),
    .i_rst    (rst),
    .io_bus   (bus2)
  );

  // Drives one clk_in cycle of stimulus and returns 1 ns after the sampling edge.
  task automatic applyStimulus(input logic sig, input logic rdy);
    bus0.sig_in     = sig;
    bus2.sig_in     = sig;
    bus0.meas_ready = rdy;
    bus2.meas_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    nVectors++;
    assert (observed === expected) else begin
      nMiscompares++;
      $error("FAIL %s observed=%0b expected=%0b", tag, observed, expected);
    end
  endtask

  task automatic checkWord(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    nVectors++;
    assert (observed === expected) else begin
      nMiscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " rise"},  bus0.rise_pulse, 1'b0);
    checkOutput({tag, " fall"},  bus0.fall_pulse, 1'b0);
    checkWord  ({tag, " period"}, bus0.period, 16'd0);
    checkWord  ({tag, " high"},  bus0.high_time, 16'd0);
    checkOutput({tag, " valid"}, bus0.meas_valid, 1'b0);
    checkOutput({tag, " lost"},  bus0.meas_lost, 1'b0);
    checkOutput({tag, " stall"}, bus0.stall, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    checkAllZero("reset");
    checkOutput("reset sync2 valid", bus2.meas_valid, 1'b0);
    checkOutput("reset sync2 rise", bus2.rise_pulse, 1'b0);
    rst = 1'b0;

    // Divide-by-2: sig_in high on odd cycles, checked on both meters.
    for (int i = 1; i <= 12; i++) begin
      applyStimulus(i % 2 == 1, 1'b1);
      checkOutput("div2 rise", bus0.rise_pulse, i % 2 == 1);
      checkOutput("div2 fall", bus0.fall_pulse, i % 2 == 0);
      checkOutput("div2 valid", bus0.meas_valid, i % 2 == 1 && i >= 3);
      if (i % 2 == 1 && i >= 3) begin
        checkWord("div2 period", bus0.period, 16'd2);
        checkWord("div2 high", bus0.high_time, 16'd1);
      end
      checkOutput("sync2 rise", bus2.rise_pulse, i % 2 == 1 && i >= 3);
      checkOutput("sync2 fall", bus2.fall_pulse, i % 2 == 0 && i >= 4);
      checkOutput("sync2 valid", bus2.meas_valid, i % 2 == 1 && i >= 5);
      if (i % 2 == 1 && i >= 5) begin
        checkWord("sync2 period", bus2.period, 16'd2);
        checkWord("sync2 high", bus2.high_time, 16'd1);
      end
    end

    rst = 1'b1;
    applyStimulus(1'b0, 1'b1);
    rst = 1'b0;
    checkOutput("rearm valid", bus0.meas_valid, 1'b0);

    // 10 high / 6 low: the first rise only arms the meter.
    for (int p = 0; p < 4; p++) begin
      for (int j = 1; j <= 16; j++) begin
        applyStimulus(j <= 10, 1'b1);
        if (j == 1) begin
          checkOutput("p16 rise", bus0.rise_pulse, 1'b1);
          checkOutput("p16 valid", bus0.meas_valid, p > 0);
          if (p > 0) begin
            checkWord("p16 period", bus0.period, 16'd16);
            checkWord("p16 high", bus0.high_time, 16'd10);
          end
        end
        if (j == 2) begin
          checkOutput("p16 rise gone", bus0.rise_pulse, 1'b0);
          checkOutput("p16 valid cleared", bus0.meas_valid, 1'b0);
        end
        if (j == 11) begin
          checkOutput("p16 fall", bus0.fall_pulse, 1'b1);
        end
      end
    end

    // Consumer stalled: first result held, later ones dropped; third period is 12/6.
    for (int q = 0; q < 3; q++) begin
      for (int j = 1; j <= ((q == 2) ? 18 : 16); j++) begin
        applyStimulus(j <= ((q == 2) ? 12 : 10), 1'b0);
        if (j == 1) begin
          checkOutput("hold valid", bus0.meas_valid, 1'b1);
          checkOutput("hold lost", bus0.meas_lost, q >= 1);
          checkWord("hold period", bus0.period, 16'd16);
          checkWord("hold high", bus0.high_time, 16'd10);
        end
      end
    end
    checkWord("hold period stable", bus0.period, 16'd16);

    applyStimulus(1'b1, 1'b1);
    checkOutput("xfer+new valid", bus0.meas_valid, 1'b1);
    checkOutput("xfer+new lost", bus0.meas_lost, 1'b0);
    checkWord("xfer+new period", bus0.period, 16'd18);
    checkWord("xfer+new high", bus0.high_time, 16'd12);

    // Divider stops low after a short high phase; stall 20 cycles after the cnt=1 load.
    for (int k = 2; k <= 25; k++) begin
      applyStimulus(k <= 5, 1'b1);
      if (k == 2) checkOutput("stall valid cleared", bus0.meas_valid, 1'b0);
      if (k >= 19) checkOutput("stall level", bus0.stall, k >= 21);
    end

    applyStimulus(1'b1, 1'b1);
    checkOutput("restart rise", bus0.rise_pulse, 1'b1);
    checkOutput("restart stall cleared", bus0.stall, 1'b0);
    checkOutput("restart no meas", bus0.meas_valid, 1'b0);

    for (int k = 2; k <= 9; k++) begin
      applyStimulus(k <= 3 || k == 9, 1'b1);
      checkOutput("restart valid", bus0.meas_valid, k == 9);
    end
    checkWord("restart period", bus0.period, 16'd8);
    checkWord("restart high", bus0.high_time, 16'd3);

    // Pending result plus a measurement in LOW, then reset.
    for (int k = 10; k <= 14; k++) begin
      applyStimulus(k <= 11, 1'b0);
    end
    checkOutput("pre-reset pending", bus0.meas_valid, 1'b1);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0);
    checkAllZero("midreset");
    rst = 1'b0;

    nValid = 0;
    for (int m = 1; m <= 12; m++) begin
      applyStimulus(m <= 2 || m == 5 || m == 6, 1'b1);
      if (bus0.meas_valid) nValid++;
      if (m == 1) checkOutput("post-reset rise", bus0.rise_pulse, 1'b1);
      if (m == 5) begin
        checkOutput("post-reset valid", bus0.meas_valid, 1'b1);
        checkWord("post-reset period", bus0.period, 16'd4);
        checkWord("post-reset high", bus0.high_time, 16'd2);
      end
    end
    checkWord("post-reset meas count", 16'(nValid), 16'd1);
    checkOutput("post-reset lost", bus0.meas_lost, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
